// File: rtl/div_mul_control_sequencer_if.sv
// ----------------------------------------------------------------------------
// div_mul_control_sequencer_if
// Groups the sequencer's request inputs and datapath control outputs.
//   start, mem_ready, ir : driven by the requester / memory side
//   datapath strobes      : PCout .. HIin, one bit each
//   Rin, Rout             : one-hot register load / bus-drive enables
//   ALUSelection          : ALU operation code (valid in T4 only)
//   busy, done, illegal   : status; done/illegal are one-cycle pulses
// Modports: master drives the requests, slave is the sequencer itself.
// ----------------------------------------------------------------------------
interface div_mul_control_sequencer_if;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;

    logic        PCout, MARin, IncPC, Zin, ZLOin, PCin, Read, MDRin;
    logic        MDRout, IRin, Yin, Yout, ZLOout, ZHIout, Loin, HIin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  ALUSelection;
    logic        busy, done, illegal;

    modport master (
        output start, mem_ready, ir,
        input  PCout, MARin, IncPC, Zin, ZLOin, PCin, Read, MDRin,
        input  MDRout, IRin, Yin, Yout, ZLOout, ZHIout, Loin, HIin,
        input  Rin, Rout, ALUSelection, busy, done, illegal
    );

    modport slave (
        input  start, mem_ready, ir,
        output PCout, MARin, IncPC, Zin, ZLOin, PCin, Read, MDRin,
        output MDRout, IRin, Yin, Yout, ZLOout, ZHIout, Loin, HIin,
        output Rin, Rout, ALUSelection, busy, done, illegal
    );
endinterface

// File: rtl/div_mul_control_sequencer.sv
// ----------------------------------------------------------------------------
// div_mul_control_sequencer
// Moore sequencer that fetches one instruction and, for MUL/DIV, walks the
// datapath through operand load, ALU operation and LO/HI write-back.
//   clk : rising-edge clock
//   clr : asynchronous active-high reset, forces IDLE (all outputs low)
//   bus : slave side of div_mul_control_sequencer_if (requests in, strobes out)
// Outputs are decoded from the registered state; ir only steers the T3/T4
// register selects and ALU code, so ir must be held stable through T4.
// ----------------------------------------------------------------------------
module div_mul_control_sequencer (
    input  logic                          clk,
    input  logic                          clr,
    div_mul_control_sequencer_if.slave    bus
);
    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, ILLEGAL
    } state_e;

    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b00101;

    state_e     state_q, state_d;
    logic [4:0] opcode;
    logic [3:0] ra, rb;
    logic       is_muldiv;
    logic       unused_ir_bits;

    assign opcode         = bus.ir[31:27];
    assign ra             = bus.ir[26:23];
    assign rb             = bus.ir[22:19];
    assign unused_ir_bits = ^bus.ir[18:0];
    assign is_muldiv      = (opcode == OP_MUL) || (opcode == OP_DIV);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        bus.PCout        = 1'b0;
        bus.MARin        = 1'b0;
        bus.IncPC        = 1'b0;
        bus.Zin          = 1'b0;
        bus.ZLOin        = 1'b0;
        bus.PCin         = 1'b0;
        bus.Read         = 1'b0;
        bus.MDRin        = 1'b0;
        bus.MDRout       = 1'b0;
        bus.IRin         = 1'b0;
        bus.Yin          = 1'b0;
        bus.Yout         = 1'b0;
        bus.ZLOout       = 1'b0;
        bus.ZHIout       = 1'b0;
        bus.Loin         = 1'b0;
        bus.HIin         = 1'b0;
        bus.Rin          = 16'h0000;   // this block never loads a GPR
        bus.Rout         = 16'h0000;
        bus.ALUSelection = 5'b00000;
        bus.done         = 1'b0;
        bus.illegal      = 1'b0;
        bus.busy         = (state_q != IDLE);

        unique case (state_q)
            IDLE: if (bus.start) state_d = T0;
            T0: begin
                // PC -> MAR and PC+1 -> Z in the same cycle
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                bus.ZLOin = 1'b1;
                state_d   = T1;
            end
            T1: begin
                // strobes stay up for every wait cycle until memory answers
                bus.ZLOout = 1'b1;
                bus.PCin   = 1'b1;
                bus.Read   = 1'b1;
                bus.MDRin  = 1'b1;
                if (bus.mem_ready) state_d = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = T3;
            end
            T3: begin
                if (is_muldiv) begin
                    bus.Rout = 16'h0001 << ra;
                    bus.Yin  = 1'b1;
                    state_d  = T4;
                end else begin
                    state_d  = ILLEGAL;
                end
            end
            T4: begin
                bus.Yout         = 1'b1;
                bus.Rout         = 16'h0001 << rb;
                bus.Zin          = 1'b1;
                bus.ZLOin        = 1'b1;
                bus.ALUSelection = opcode;
                state_d          = T5;
            end
            T5: begin
                bus.ZLOout = 1'b1;
                bus.Loin   = 1'b1;
                state_d    = T6;
            end
            T6: begin
                bus.ZHIout = 1'b1;
                bus.HIin   = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            ILLEGAL: begin
                bus.illegal = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
